// File: rtl/nf10_axis_pkt_checker.sv
// nf10_axis_pkt_checker: AXI4-Stream sink that checks generator test packets
// (HDR0, HDR1, counter-stamped payload) and keeps pass/fail counters and sticky flags.
module nf10_axis_pkt_checker #(
  parameter int unsigned  C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned  C_PAYLOAD_WORDS      = 32,
  parameter logic [255:0] C_HDR0               = {4{64'hEFBEFECAFECAFECA}},
  parameter logic [255:0] C_HDR1               = {4{64'h00000008EFBEEFBE}},
  parameter bit           C_BP_ENABLE          = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [255:0]                    s_axis_tdata,
  input  logic [31:0]                     s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic                            clear,
  output logic [31:0]                     pkt_good_cnt,
  output logic [31:0]                     pkt_bad_cnt,
  output logic                            err_hdr,
  output logic                            err_payload,
  output logic                            err_len,
  output logic [8:0]                      last_err_idx,
  output logic                            busy
);

  localparam int unsigned   DATA_W   = 256;
  localparam int unsigned   CNT_W    = 32;
  localparam int unsigned   IDX_W    = 9;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_PAYLOAD_WORDS - 1);

  typedef enum logic [1:0] {S_HDR0, S_HDR1, S_PAYLOAD, S_DRAIN} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   pidx, pidx_next;
  logic               pkt_bad, pkt_bad_next;
  logic [3:0]         lfsr, lfsr_next;
  logic               tready_next, busy_next;
  logic [CNT_W-1:0]   good_next, bad_next;
  logic               err_hdr_next, err_payload_next, err_len_next;
  logic [IDX_W-1:0]   last_err_idx_next;
  logic               beat, hdr_e, pay_e, len_e, done;
  logic [IDX_W-1:0]   e_idx;

  // TUSER carries nothing this checker needs
  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  // Expected payload word k, stamped with the low byte of its index
  function automatic logic [DATA_W-1:0] payload_word(input logic [IDX_W-1:0] k);
    logic [7:0] b;
    b = k[7:0];
    return {{8{b}}, 64'hAAAAAAAABBBBBBBB, {8{b}}, 64'hBBBBBBBBCCCCCCCC};
  endfunction

  // Counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign beat = s_axis_tvalid & s_axis_tready;

  // Next-state, per-beat checks, counters, flags and ready generation
  always_comb begin
    state_next        = state;
    pidx_next         = pidx;
    pkt_bad_next      = pkt_bad;
    good_next         = pkt_good_cnt;
    bad_next          = pkt_bad_cnt;
    err_hdr_next      = err_hdr;
    err_payload_next  = err_payload;
    err_len_next      = err_len;
    last_err_idx_next = last_err_idx;
    hdr_e             = 1'b0;
    pay_e             = 1'b0;
    len_e             = 1'b0;
    done              = 1'b0;
    e_idx             = '0;
    lfsr_next         = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    tready_next       = C_BP_ENABLE ? (lfsr_next[1:0] != 2'b00) : 1'b1;

    case (state)
      S_HDR0: if (beat) begin
        hdr_e = (s_axis_tdata != C_HDR0);
        e_idx = IDX_W'(0);
        if (s_axis_tlast) begin
          len_e = 1'b1;
          done  = 1'b1;
        end else begin
          state_next = S_HDR1;
        end
      end
      S_HDR1: if (beat) begin
        hdr_e = (s_axis_tdata != C_HDR1);
        e_idx = IDX_W'(1);
        if (s_axis_tlast) begin
          len_e = 1'b1;
          done  = 1'b1;
        end else begin
          state_next = S_PAYLOAD;
          pidx_next  = '0;
        end
      end
      S_PAYLOAD: if (beat) begin
        pay_e = (s_axis_tdata != payload_word(pidx)) || (s_axis_tstrb != '1);
        e_idx = pidx + IDX_W'(2);
        if (s_axis_tlast) begin
          len_e = (pidx != LAST_IDX);
          done  = 1'b1;
        end else if (pidx == LAST_IDX) begin
          len_e      = 1'b1;
          state_next = S_DRAIN;
        end else begin
          pidx_next = pidx + IDX_W'(1);
        end
      end
      S_DRAIN: if (beat && s_axis_tlast) done = 1'b1;
      default: state_next = S_HDR0;
    endcase

    if (hdr_e || pay_e || len_e) begin
      err_hdr_next      = err_hdr | hdr_e;
      err_payload_next  = err_payload | pay_e;
      err_len_next      = err_len | len_e;
      last_err_idx_next = e_idx;
      pkt_bad_next      = 1'b1;
    end

    if (done) begin
      state_next   = S_HDR0;
      pkt_bad_next = 1'b0;
      if (pkt_bad || hdr_e || pay_e || len_e) bad_next = sat_inc(pkt_bad_cnt);
      else                                    good_next = sat_inc(pkt_good_cnt);
    end

    // Clear wins over any same-cycle update but leaves packet tracking alone
    if (clear) begin
      good_next         = '0;
      bad_next          = '0;
      err_hdr_next      = 1'b0;
      err_payload_next  = 1'b0;
      err_len_next      = 1'b0;
      last_err_idx_next = '0;
    end

    busy_next = (state_next != S_HDR0);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_HDR0;
      pidx          <= '0;
      pkt_bad       <= 1'b0;
      lfsr          <= 4'b1001;
      s_axis_tready <= 1'b0;
      pkt_good_cnt  <= '0;
      pkt_bad_cnt   <= '0;
      err_hdr       <= 1'b0;
      err_payload   <= 1'b0;
      err_len       <= 1'b0;
      last_err_idx  <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      pidx          <= pidx_next;
      pkt_bad       <= pkt_bad_next;
      lfsr          <= lfsr_next;
      s_axis_tready <= tready_next;
      pkt_good_cnt  <= good_next;
      pkt_bad_cnt   <= bad_next;
      err_hdr       <= err_hdr_next;
      err_payload   <= err_payload_next;
      err_len       <= err_len_next;
      last_err_idx  <= last_err_idx_next;
      busy          <= busy_next;
    end
  end

endmodule

// File: tb/tb_nf10_axis_pkt_checker.sv
// Bench for nf10_axis_pkt_checker: directed and random packets, packet-level reference model.
module tb_nf10_axis_pkt_checker;

  localparam int N = 32;
  localparam logic [255:0] HDR0 = {4{64'hEFBEFECAFECAFECA}};
  localparam logic [255:0] HDR1 = {4{64'h00000008EFBEEFBE}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, clear;
  logic [255:0] d_tdata [2];
  logic [31:0]  d_tstrb [2];
  logic         d_tvalid[2];
  logic         d_tlast [2];
  logic [127:0] tuser;

  logic        r0_tready, r0_eh, r0_ep, r0_el, r0_busy;
  logic [31:0] r0_good, r0_bad;
  logic [8:0]  r0_idx;
  logic        r1_tready, r1_eh, r1_ep, r1_el, r1_busy;
  logic [31:0] r1_good, r1_bad;
  logic [8:0]  r1_idx;

  nf10_axis_pkt_checker #(.C_BP_ENABLE(1'b0)) u0 (
    .clk(clk), .reset(reset), .s_axis_tdata(d_tdata[0]), .s_axis_tstrb(d_tstrb[0]),
    .s_axis_tuser(tuser), .s_axis_tvalid(d_tvalid[0]), .s_axis_tready(r0_tready),
    .s_axis_tlast(d_tlast[0]), .clear(clear), .pkt_good_cnt(r0_good), .pkt_bad_cnt(r0_bad),
    .err_hdr(r0_eh), .err_payload(r0_ep), .err_len(r0_el), .last_err_idx(r0_idx), .busy(r0_busy));

  nf10_axis_pkt_checker #(.C_BP_ENABLE(1'b1)) u1 (
    .clk(clk), .reset(reset), .s_axis_tdata(d_tdata[1]), .s_axis_tstrb(d_tstrb[1]),
    .s_axis_tuser(tuser), .s_axis_tvalid(d_tvalid[1]), .s_axis_tready(r1_tready),
    .s_axis_tlast(d_tlast[1]), .clear(clear), .pkt_good_cnt(r1_good), .pkt_bad_cnt(r1_bad),
    .err_hdr(r1_eh), .err_payload(r1_ep), .err_len(r1_el), .last_err_idx(r1_idx), .busy(r1_busy));

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit bp_watch = 1'b0;
  bit saw_low  = 1'b0;

  function automatic logic [255:0] pay(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {{8{b}}, 64'hAAAAAAAABBBBBBBB, {8{b}}, 64'hBBBBBBBBCCCCCCCC};
  endfunction

  function automatic logic [255:0] pos_word(input int p);
    if (p == 0) return HDR0;
    if (p == 1) return HDR1;
    return pay(p - 2);
  endfunction

  function automatic logic rdy(input int u);
    return (u == 0) ? r0_tready : r1_tready;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model of unit 0 (packet position based) ----------------
  int          m_pos = 0;
  bit          m_bad = 1'b0;
  logic [31:0] e_good = '0, e_bad = '0;
  logic        e_eh = 1'b0, e_ep = 1'b0, e_el = 1'b0, e_busy = 1'b0, e_rdy = 1'b0;
  logic [8:0]  e_idx = '0;

  // Model updates on each edge from what the bench presented and whether it was accepted
  always @(posedge clk) begin : mdl
    logic eh, ep, el;
    eh = 1'b0; ep = 1'b0; el = 1'b0;
    if (reset) begin
      m_pos = 0; m_bad = 1'b0; e_good = '0; e_bad = '0;
      e_eh = 1'b0; e_ep = 1'b0; e_el = 1'b0; e_idx = '0; e_busy = 1'b0; e_rdy = 1'b0;
    end else begin
      if (d_tvalid[0] && r0_tready) begin
        if (m_pos < 2) begin
          eh = (d_tdata[0] !== ((m_pos == 0) ? HDR0 : HDR1));
          el = d_tlast[0];
        end else if (m_pos < N + 2) begin
          ep = (d_tdata[0] !== pay(m_pos - 2)) || (d_tstrb[0] !== 32'hFFFFFFFF);
          el = d_tlast[0] ? (m_pos != N + 1) : (m_pos == N + 1);
        end
        if (eh || ep || el) begin
          e_eh |= eh; e_ep |= ep; e_el |= el;
          e_idx = 9'(m_pos);
          m_bad = 1'b1;
        end
        if (d_tlast[0]) begin
          if (m_bad) e_bad  = (e_bad  == 32'hFFFFFFFF) ? e_bad  : e_bad + 1;
          else       e_good = (e_good == 32'hFFFFFFFF) ? e_good : e_good + 1;
          m_bad = 1'b0;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
      e_busy = (m_pos != 0);
      e_rdy  = 1'b1;
      if (clear) begin
        e_good = '0; e_bad = '0; e_eh = 1'b0; e_ep = 1'b0; e_el = 1'b0; e_idx = '0;
      end
    end
  end

  // Compare unit 0 against the model every cycle, away from the clock edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("tready", 32'(r0_tready), 32'(e_rdy));
      cmp("good_cnt", r0_good, e_good);
      cmp("bad_cnt", r0_bad, e_bad);
      cmp("err_hdr", 32'(r0_eh), 32'(e_eh));
      cmp("err_payload", 32'(r0_ep), 32'(e_ep));
      cmp("err_len", 32'(r0_el), 32'(e_el));
      cmp("last_err_idx", 32'(r0_idx), 32'(e_idx));
      cmp("busy", 32'(r0_busy), 32'(e_busy));
    end
  end

  // Backpressure observation for unit 1
  always @(negedge clk) if (bp_watch && !r1_tready) saw_low = 1'b1;

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // One beat: present at a negedge, hold until accepted, return at the negedge after acceptance
  task automatic put(input int u, input logic [255:0] d, input logic [31:0] s,
                     input logic l, input logic clr, input int gap);
    int n;
    if (gap > 0) begin
      d_tvalid[u] = 1'b0;
      repeat (gap) @(negedge clk);
    end
    d_tvalid[u] = 1'b1; d_tdata[u] = d; d_tstrb[u] = s; d_tlast[u] = l; clear = clr;
    n = 0;
    while (!rdy(u) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL ready_timeout unit=%0d actual=tready_low required=accept t=%0t", u, $time);
    end
    @(negedge clk);
    d_tvalid[u] = 1'b0; d_tlast[u] = 1'b0; clear = 1'b0;
  endtask

  // Packet of nbeats words (position 0 = HDR0) with up to two corruptions
  // mode 1: flip byte 0, mode 2: zero data, mode 3: half TSTRB
  task automatic send_pkt(input int u, input int nbeats, input bit no_last,
                          input int cp1, input int cm1, input int cp2, input int cm2,
                          input bit clr_last, input int maxgap);
    for (int p = 0; p < nbeats; p++) begin
      logic [255:0] d;
      logic [31:0]  s;
      logic         l;
      int           g;
      d = pos_word(p);
      s = 32'hFFFFFFFF;
      for (int c = 0; c < 2; c++) begin
        int cp, cm;
        cp = (c == 0) ? cp1 : cp2;
        cm = (c == 0) ? cm1 : cm2;
        if (cp == p) begin
          if (cm == 1) d = d ^ 256'hFF;
          if (cm == 2) d = '0;
          if (cm == 3) s = 32'h0000FFFF;
        end
      end
      l = (p == nbeats - 1) && !no_last;
      g = (maxgap > 0 && ($urandom % 4) == 0) ? int'($urandom_range(1, maxgap)) : 0;
      put(u, d, s, l, clr_last && l, g);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; tuser = '0;
    for (int u = 0; u < 2; u++) begin
      d_tdata[u] = '0; d_tstrb[u] = '0; d_tvalid[u] = 1'b0; d_tlast[u] = 1'b0;
    end
    idle(2);
    chk_en = 1'b1;
    cmp("rst_tready", 32'(r0_tready), 32'd0);
    cmp("rst_good", r0_good, 32'd0);
    cmp("rst_busy", 32'(r0_busy), 32'd0);
    @(negedge clk); reset = 1'b0;
    idle(1);

    // Backpressured unit: 4 back-to-back good packets
    bp_watch = 1'b1;
    repeat (4) send_pkt(1, N + 2, 1'b0, -1, 0, -1, 0, 1'b0, 0);
    idle(2);
    cmp("bp_good", r1_good, 32'd4);
    cmp("bp_bad", r1_bad, 32'd0);
    cmp("bp_flags", 32'({r1_eh, r1_ep, r1_el}), 32'd0);
    cmp("bp_saw_low", 32'(saw_low), 32'd1);
    bp_watch = 1'b0;

    // Generator packet
    send_pkt(0, N + 2, 1'b0, -1, 0, -1, 0, 1'b0, 0);
    idle(1);
    cmp("gen_good", r0_good, 32'd1);
    cmp("gen_bad", r0_bad, 32'd0);
    cmp("gen_flags", 32'({r0_eh, r0_ep, r0_el}), 32'd0);

    // Payload k=5 byte 0 flipped, then a good packet
    pulse_clear();
    send_pkt(0, N + 2, 1'b0, 7, 1, -1, 0, 1'b0, 0);
    idle(1);
    cmp("flip_bad", r0_bad, 32'd1);
    cmp("flip_errp", 32'(r0_ep), 32'd1);
    cmp("flip_idx", 32'(r0_idx), 32'd7);
    send_pkt(0, N + 2, 1'b0, -1, 0, -1, 0, 1'b0, 0);
    cmp("flip_next_good", r0_good, 32'd1);

    // TLAST early on payload k=10
    pulse_clear();
    send_pkt(0, 13, 1'b0, -1, 0, -1, 0, 1'b0, 0);
    idle(1);
    cmp("early_errlen", 32'(r0_el), 32'd1);
    cmp("early_idx", 32'(r0_idx), 32'd12);
    cmp("early_bad", r0_bad, 32'd1);

    // 40 payload words
    pulse_clear();
    send_pkt(0, 42, 1'b0, -1, 0, -1, 0, 1'b0, 0);
    idle(1);
    cmp("long_errlen", 32'(r0_el), 32'd1);
    cmp("long_idx", 32'(r0_idx), 32'd33);
    cmp("long_bad", r0_bad, 32'd1);
    cmp("long_good", r0_good, 32'd0);

    // HDR1 zero and short TSTRB on payload 0
    pulse_clear();
    send_pkt(0, N + 2, 1'b0, 1, 2, 2, 3, 1'b0, 0);
    idle(1);
    cmp("hs_errhdr", 32'(r0_eh), 32'd1);
    cmp("hs_errp", 32'(r0_ep), 32'd1);
    cmp("hs_idx", 32'(r0_idx), 32'd2);
    cmp("hs_bad", r0_bad, 32'd1);

    // Clear coinciding with a good completion
    pulse_clear();
    send_pkt(0, N + 2, 1'b0, -1, 0, -1, 0, 1'b1, 0);
    cmp("clr_coincide_good", r0_good, 32'd0);
    idle(1);

    // Reset in place of payload word 12
    send_pkt(0, 14, 1'b1, -1, 0, -1, 0, 1'b0, 0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    cmp("rstmid_good", r0_good, 32'd0);
    cmp("rstmid_busy", 32'(r0_busy), 32'd0);
    send_pkt(0, N + 2, 1'b0, -1, 0, -1, 0, 1'b0, 0);
    idle(1);
    cmp("rstmid_next_good", r0_good, 32'd1);
    cmp("rstmid_next_bad", r0_bad, 32'd0);

    // Random packets with gaps and corruptions
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom % 8);
      case (kind)
        4:       send_pkt(0, N + 2, 1'b0, int'($urandom_range(0, N + 1)), 1, -1, 0, 1'b0, 3);
        5:       send_pkt(0, N + 2, 1'b0, int'($urandom_range(2, N + 1)), 3, -1, 0, 1'b0, 3);
        6:       send_pkt(0, int'($urandom_range(1, N + 1)), 1'b0, -1, 0, -1, 0, 1'b0, 3);
        7:       send_pkt(0, N + 2 + int'($urandom_range(1, 5)), 1'b0, -1, 0, -1, 0, 1'b0, 3);
        default: send_pkt(0, N + 2, 1'b0, -1, 0, -1, 0, 1'b0, 3);
      endcase
      idle(int'($urandom_range(0, 2)));
      if (($urandom % 10) == 0) pulse_clear();
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
